// File: rtl/shift_add_mult_ctrl_if.sv
// shift_add_mult_ctrl_if: operand/result valid-ready bundle for the shift-add multiplier.
interface shift_add_mult_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: multi-cycle unsigned shift-add multiplier with valid/ready handshakes.
// Define SHIFT_ADD_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                  clock,
    input logic                  reset_L,
    shift_add_mult_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]     mplier, mplier_nxt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [CW-1:0]        count, count_nxt;

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            count  <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        count_nxt  = count;
        case (state)
            IDLE: if (bus.in_valid) begin
                mcand_nxt  = {{WIDTH{1'b0}}, bus.A};
                mplier_nxt = bus.B;
                acc_nxt    = '0;
                count_nxt  = '0;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
                state_nxt  = (bus.B == '0) ? DONE : CALC;
`else
                state_nxt  = CALC;
`endif
            end
            CALC: begin
                acc_nxt    = mplier[0] ? acc + mcand : acc;
                mcand_nxt  = mcand << 1;
                mplier_nxt = mplier >> 1;
                count_nxt  = count + CW'(1);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
                state_nxt  = (count == LAST || mplier_nxt == '0) ? DONE : CALC;
`else
                state_nxt  = (count == LAST) ? DONE : CALC;
`endif
            end
            DONE: state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.product   = acc;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb_shift_add_mult_ctrl: directed vectors plus a latency/product model checked every cycle.
module tb_shift_add_mult_ctrl;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset_L = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    shift_add_mult_ctrl_if #(.WIDTH(W)) bus ();
    shift_add_mult_ctrl #(.WIDTH(W)) dut (.clock(clock), .reset_L(reset_L), .bus(bus));

    always #5 clock = ~clock;

    // Expected CALC cycles for a given multiplier in this build.
    function automatic int lat_of(logic [W-1:0] b);
        int l;
        l = W;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        l = 0;
        for (int i = 0; i < W; i++) if (b[i]) l = i + 1;
`endif
        return l;
    endfunction

    function automatic int el(int early, int fixed);
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
        return early;
`else
        return fixed;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy from acceptance until handshake, valid after the latency.
    logic           m_busy = 1'b0;
    int             m_left = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] m_last = '0;

    always @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            m_busy = 1'b0;
            m_left = 0;
            m_prod = '0;
            m_last = '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                m_busy = 1'b1;
                m_prod = (2*W)'(bus.A) * (2*W)'(bus.B);
                m_left = lat_of(bus.B);
            end
        end else if (m_left > 0) begin
            m_left--;
        end else if (bus.out_ready) begin
            m_busy = 1'b0;
            m_last = m_prod;
        end
    end

    always @(negedge clock) begin
        chk("m_in_ready", bus.in_ready, !m_busy);
        chk("m_busy", bus.busy, m_busy);
        chk("m_out_valid", bus.out_valid, m_busy && m_left == 0);
        if (m_busy && m_left == 0) chk("m_product", bus.product, m_prod);
        if (!m_busy) chk("m_idle_product", bus.product, m_last);
    end

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic run(logic [W-1:0] a, logic [W-1:0] b, logic [2*W-1:0] exp, int lat, int stall);
        int n;
        @(negedge clock);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        chk("accept_ready", bus.in_ready, 1);
        @(negedge clock);
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("latency", n, lat);
        chk("product", bus.product, exp);
        if (stall > 0) begin
            bus.A = 2;
            bus.B = 2;
            bus.in_valid = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("stall_product", bus.product, exp);
            chk("stall_valid", bus.out_valid, 1);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk("post_in_ready", bus.in_ready, 1);
        chk("post_valid", bus.out_valid, 0);
        chk("post_product", bus.product, exp);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0;
        bus.B = '0;
        #1 reset_L = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_product", bus.product, 0);
        #2 reset_L = 1'b1;

        run(8'hFF, 8'hFF, 16'hFE01, 8, 0);
        run(8'd13, 8'd11, 16'd143, el(4, 8), 5);
        run(8'h80, 8'h00, 16'h0000, el(0, 8), 0);
        run(8'd5, 8'd3, 16'd15, el(2, 8), 0);
        run(8'd1, 8'h80, 16'd128, 8, 1);
        run(8'd0, 8'hFF, 16'd0, 8, 0);

        // Back-to-back with both valids held high.
        @(negedge clock);
        bus.A = 8'd7;
        bus.B = 8'd6;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.A = 8'd200;
        bus.B = 8'd3;
        wait_valid(n);
        chk("b2b_lat1", n, el(3, 8));
        chk("b2b_prod1", bus.product, 16'd42);
        @(negedge clock);
        chk("b2b_gap_busy", bus.busy, 0);
        chk("b2b_gap_ready", bus.in_ready, 1);
        @(negedge clock);
        chk("b2b_second_busy", bus.busy, 1);
        bus.in_valid = 1'b0;
        wait_valid(n);
        chk("b2b_lat2", n, el(2, 8));
        chk("b2b_prod2", bus.product, 16'd600);
        @(negedge clock);
        bus.out_ready = 1'b0;
        chk("b2b_end_busy", bus.busy, 0);

        // Reset abandons an in-flight operation.
        @(negedge clock);
        bus.A = 8'h0F;
        bus.B = 8'h0F;
        bus.in_valid = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        #2 reset_L = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.in_ready, 1);
        chk("mid_rst_product", bus.product, 0);
        repeat (2) @(negedge clock);
        #2 reset_L = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (bus.out_valid) n++;
        end
        chk("no_done_after_rst", n, 0);

        run(8'd9, 8'd9, 16'd81, el(4, 8), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/shift_add_mult_ctrl.md
# shift_add_mult_ctrl

- Multi-cycle unsigned shift-add multiplier.
- A controller FSM sequences a 2·WIDTH accumulator add, a left-shifting multiplicand register, a right-shifting multiplier register and an iteration counter.
- Uses a valid/ready handshake on both input and output.
- Low-area multiply unit for datapaths that cannot afford a combinational array multiplier.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; WIDTH ≥ 2.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A/B present.
- in_ready  output  1  block can accept operands; equals (state == IDLE).
- A  input  WIDTH  multiplicand, unsigned.
- B  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product valid; equals (state == DONE).
- out_ready  input  1  consumer takes product.
- product  output  2·WIDTH  registered result.
- busy  output  1  state ≠ IDLE.

## Operation
Internal state:
- mcand: 2·WIDTH bits.
- mplier: WIDTH bits.
- acc: 2·WIDTH bits; drives product directly.
- count: $clog2(WIDTH) bits.
- FSM: IDLE, CALC, DONE.

State transitions:
- **IDLE**
  - in_ready = 1.
  - On in_valid: load mcand = zero-extended A, mplier = B, acc = 0, count = 0, then go to CALC.
  - Otherwise hold; acc keeps the previous product.
- **CALC**, one iteration per cycle:
  - If mplier[0], acc ← acc + mcand; else acc unchanged.
  - mcand ← mcand << 1; mplier ← mplier >> 1; count ← count + 1.
  - When count == WIDTH−1, go to DONE.
  - in_valid is ignored.
- **DONE**
  - out_valid = 1; product = acc.
  - On out_ready, go to IDLE.
  - product stays stable while out_ready is low.

Arithmetic and ordering rules:
- Accumulator addition is 2·WIDTH wide and cannot overflow (max (2^W−1)^2 < 2^(2W)); carry-out is discarded.
- No transaction overlap: a new operand pair is never accepted in the same cycle as the out handshake.

## Timing
Reset:
- While reset_L is low: state = IDLE, acc/product = 0, mcand = mplier = count = 0, out_valid = 0, busy = 0, in_ready = 1.
- Reset asserted mid-CALC or mid-DONE abandons the operation. No output is produced and product reads 0.

Latency and throughput:
- Let the acceptance edge be E (in_valid & in_ready sampled high).
- CALC occupies edges E+1 … E+WIDTH.
- out_valid is high from edge E+WIDTH until the edge on which out_ready is sampled high.
- The following cycle is IDLE with in_ready = 1.
- Minimum throughput: one operation per WIDTH+2 cycles.

Handshake rules:
- out_valid never deasserts without out_ready.
- A, B, in_valid may change freely while in_ready = 0.
- Simultaneous in_valid and reset_L low: reset wins, nothing is accepted.

## Configuration
Macro: SHIFT_ADD_MULT_EARLY_EXIT_EN.
- **Defined**, early termination:
  - In IDLE, if B == 0, the acceptance edge goes directly to DONE with acc = 0, so out_valid is high right after edge E.
  - In CALC, go to DONE on the edge where the shifted mplier becomes 0, or on count == WIDTH−1, whichever comes first.
  - Latency = position of the highest set bit of B plus 1 CALC cycles, or 0 CALC cycles for B == 0.
- **Undefined**: latency is fixed at WIDTH CALC cycles for all operands.
- Result values are identical in both builds.

## Test plan
- **Reset mid-operation:** WIDTH=8, accept A=8'h0F, B=8'h0F, pull reset_L low 3 cycles later → out_valid = 0, busy = 0, in_ready = 1, product = 16'h0000 immediately (asynchronously). No DONE after release.
- **Maximum operands:** A=8'hFF, B=8'hFF, macro undefined → product = 16'hFE01; out_valid first high exactly 8 edges after acceptance.
- **Backpressure:** A=13, B=11, out_ready held low 5 cycles after out_valid → product = 143 stable, out_valid held 1, in_ready = 0. A new in_valid with A=2, B=2 is ignored (not accepted).
- **Zero multiplier:** A=8'h80, B=8'h00 → product = 0. out_valid comes 8 edges after acceptance with the macro undefined; the macro defined → out_valid high right after the acceptance edge.
- **Early exit:** macro defined, A=5, B=3 → product = 15, out_valid after 2 CALC edges. A=1, B=8'h80 → product = 128 after 8 CALC edges.
- **Back-to-back:** in_valid and out_ready held high, pairs (7,6) then (200,3) → products 42 then 600. Second acceptance occurs exactly one cycle after the first out handshake; busy drops for that IDLE cycle only.
